dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port data memory between the pipeline MEM stage and an external debug/loader port.
- The pipeline is the default owner and gets priority.
- A debug access takes one extra memory cycle. During that cycle the block asserts pipe_hold, which freezes every pipeline stage register (F through W) while a MEM access is pending.
- A starvation counter guarantees that debug accesses make progress under continuous pipeline memory traffic.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MAX_STARVE, 4, number of consecutive pipeline-won conflicts after which a waiting debug request is forcibly granted (0 = debug always wins a conflict).
- CW, 3, starve counter width; must satisfy 2^CW-1 >= MAX_STARVE.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- p_req  in  1  MEM stage memory access (MemWriteM | MemtoRegM)
- p_we  in  1  MEM stage write enable
- p_addr  in  AW  MEM stage address (ALUOutM)
- p_wdata  in  DW  MEM stage write data
- p_rdata  out  DW  read data to MEM stage (combinational from mem_rd)
- pipe_hold  out  1  freeze all pipeline registers this cycle
- d_req  in  1  debug request, held until d_gnt
- d_we  in  1  debug write enable
- d_addr  in  AW  debug address
- d_wdata  in  DW  debug write data
- d_gnt  out  1  one-cycle pulse: request accepted, inputs latched
- d_rvalid  out  1  one-cycle pulse: debug access complete
- d_rdata  out  DW  debug read data, valid with d_rvalid on reads
- mem_a  out  AW  to data memory address
- mem_wd  out  DW  to data memory write data
- mem_we  out  1  to data memory write enable
- mem_rd  in  DW  from data memory, asynchronous read

Behaviour:
- States: ARB (default) and DBG_ACC.
- ARB, memory ownership:
  - mem_a = p_addr, mem_wd = p_wdata, mem_we = p_req & p_we.
  - pipe_hold = 0.
- ARB, grant rule:
  - grant = d_req & (~p_req | starve_cnt >= MAX_STARVE).
  - On grant: d_gnt=1; latch d_addr, d_wdata and d_we into lat_*; next state is DBG_ACC.
  - The pipeline access in the same cycle still completes; a debug request never preempts within a cycle.
- starve_cnt (updated in ARB only):
  - Increments, saturating, when d_req & p_req & ~grant.
  - Clears on grant or when d_req=0.
  - Holds its value in DBG_ACC.
- DBG_ACC:
  - mem_a = lat_addr, mem_wd = lat_wdata, mem_we = lat_we.
  - pipe_hold = p_req.
  - On the clock edge: if ~lat_we, d_rdata <= mem_rd; d_rvalid <= 1; next state is ARB unconditionally.
- p_rdata = mem_rd in both states. Its value is only meaningful when pipe_hold=0.
- d_rvalid:
  - High exactly in the cycle after DBG_ACC; otherwise 0.
  - Pulses for writes as well; d_rdata is unchanged after a write.
- Debug throughput:
  - At most one access per 2 cycles.
  - d_gnt may assert in the same cycle as d_rvalid.
- d_gnt is combinational from d_req in ARB. d_req must be held stable until d_gnt.
- Reset (synchronous):
  - State=ARB, starve_cnt=0, d_rvalid=0, d_rdata=0, lat_*=0.
  - Outputs after reset: pipe_hold=0, d_gnt follows d_req/p_req per the ARB grant rule.
  - Reset asserted during DBG_ACC abandons the access: no debug write occurs on that edge beyond what mem_we already presents, and no d_rvalid follows.
  - The pipeline's own reset must coincide.
- Pipe_hold semantics: the pipeline keeps p_req/p_addr/p_wdata stable while held. The access is re-issued and completes in the following ARB cycle.
- MAX_STARVE=0: any debug request wins a conflict immediately. The counter stays at 0.

Test Plan:
- Pipeline only: p_req=1, p_we=1, p_addr=0x10, p_wdata=0xDEADBEEF, d_req=0 -> mem_we=1, mem_a=0x10, pipe_hold=0, never d_gnt. A subsequent read of 0x10 gives p_rdata=0xDEADBEEF.
- Debug only: d_req=1, d_we=0, d_addr=0x10, p_req=0 -> d_gnt in cycle N, mem_a=0x10 in N+1, d_rvalid=1 and d_rdata=0xDEADBEEF in N+2, pipe_hold=0 throughout.
- Conflict and starvation, MAX_STARVE=4: p_req=1 continuously, d_req=1 from cycle 0 -> starve_cnt 1,2,3,4 over cycles 0-3. d_gnt at cycle 4, pipe_hold=1 at cycle 5, d_rvalid at cycle 6. The pipeline write at cycle 4 still lands.
- Debug write then pipeline read: debug writes 0x12345678 to 0x20 while p_req is issued to 0x20 in DBG_ACC -> pipe_hold=1 for that cycle. The next cycle p_rdata=0x12345678.
- Back-to-back debug requests with p_req=0 -> d_gnt pulses every 2 cycles, coinciding with the previous d_rvalid. 4 accesses complete in 8 cycles.
- Reset during DBG_ACC with lat_we=1 -> next cycle state=ARB, d_rvalid=0, starve_cnt=0, pipe_hold=0. No d_rvalid pulse ever appears for that access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: the pipeline MEM stage owns the single-port memory by default,
// and a debug/loader port steals one extra cycle per access, with a starvation guard.
module dmem_arbiter #(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int MAX_STARVE = 4,
  parameter int CW         = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_wdata,
  output logic [DW-1:0] p_rdata,
  output logic          pipe_hold,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
);

  typedef enum logic {
    ARB     = 1'b0,
    DBG_ACC = 1'b1
  } state_t;

  localparam logic [CW-1:0] STARVE_LIM = CW'(MAX_STARVE);

  state_t        state;
  logic [CW-1:0] starve_cnt;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          lat_we;
  logic          grant;

  // The pipeline keeps its own access in a grant cycle; the debug access runs next cycle.
  always_comb begin
    grant     = d_req & (~p_req | (starve_cnt >= STARVE_LIM));
    d_gnt     = (state == ARB) & grant;
    mem_a     = p_addr;
    mem_wd    = p_wdata;
    mem_we    = p_req & p_we;
    pipe_hold = 1'b0;
    if (state == DBG_ACC) begin
      mem_a     = lat_addr;
      mem_wd    = lat_wdata;
      mem_we    = lat_we;
      pipe_hold = p_req;
    end
  end

  assign p_rdata = mem_rd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ARB;
      starve_cnt <= '0;
      d_rvalid   <= 1'b0;
      d_rdata    <= '0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      lat_we     <= 1'b0;
    end else begin
      d_rvalid <= 1'b0;
      case (state)
        ARB: begin
          if (grant) begin
            lat_addr   <= d_addr;
            lat_wdata  <= d_wdata;
            lat_we     <= d_we;
            starve_cnt <= '0;
            state      <= DBG_ACC;
          end else if (d_req & p_req) begin
            if (starve_cnt != '1)
              starve_cnt <= starve_cnt + 1'b1;
          end else begin
            starve_cnt <= '0;
          end
        end
        DBG_ACC: begin
          if (!lat_we)
            d_rdata <= mem_rd;
          d_rvalid <= 1'b1;
          state    <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule
